cache_fill_fsm: RTL and testbench
=================================

Name: cache_fill_fsm

Overview:
- Miss-handling engine between the pipelined CPU's cache arrays and the multi-cycle main memory.
- On a cache miss it does four things:
  - latches the block address;
  - issues 8 sequential word reads to main memory;
  - writes each returned word into the cache data array;
  - writes the tag on the final word.
- Holds `fsm_busy` so the IF/MEM stages stall for the duration of the fill.

Parameters:
- `WORDS_PER_BLOCK`, 8: words per cache block. Power of 2; the offset width is log2 of this, 3 at the default.
- `AWIDTH`, 16: byte-address width.
- `DWIDTH`, 16: memory word width.

Ports:
- `clk`  input  1  system clock.
- `rst`  input  1  synchronous, active-high reset.
- `miss_detected`  input  1  cache lookup missed this cycle.
- `miss_address`  input  AWIDTH  byte address of the missing access.
- `fsm_busy`  output  1  fill in progress; stall request to the pipeline.
- `mem_read_en`  output  1  read request to main memory this cycle.
- `memory_address`  output  AWIDTH  byte address of the current read request.
- `memory_data_valid`  input  1  main memory is returning a word this cycle.
- `memory_data`  input  DWIDTH  returned word.
- `write_data_array`  output  1  write `fill_data` into the data array at `word_offset`.
- `word_offset`  output  3  word index within the block for the current data write.
- `fill_data`  output  DWIDTH  word to write; equals `memory_data`.
- `write_tag_array`  output  1  write the tag and set the valid bit for `block_address`.
- `block_address`  output  AWIDTH  aligned base address of the block being filled.

Behaviour:
- Block size is 8 words × 2 bytes = 16 bytes.
  - `block_address` = `miss_address` with bits [3:0] cleared.
  - Word k sits at `block_address` + 2k.
  - The address adder never carries out of the block, because the base is aligned.
- States: IDLE and FILL.
- IDLE:
  - `fsm_busy` = `miss_detected`. This is combinational, so the stall is immediate.
  - On a clock edge with `miss_detected`=1:
    - latch `block_address`;
    - clear `issue_cnt` and `recv_cnt`;
    - move to FILL.
- FILL, request side:
  - `fsm_busy`=1.
  - While `issue_cnt` < 8: `mem_read_en`=1, `memory_address` = base + 2·`issue_cnt`, and `issue_cnt` increments every cycle. There is one request per cycle with no backpressure; main memory is pipelined with fixed latency.
  - Once `issue_cnt` = 8, `mem_read_en`=0.
- FILL, return side:
  - On each cycle with `memory_data_valid`=1:
    - `write_data_array`=1;
    - `word_offset` = `recv_cnt`;
    - `fill_data` = `memory_data`;
    - `recv_cnt` increments.
  - The number of cycles between request and data is not counted internally; only `memory_data_valid` is used. Valid may arrive with gaps.
- Completion:
  - In the cycle of the 8th valid (`recv_cnt`=7), `write_tag_array`=1 together with that final data write.
  - Next state is IDLE, and `fsm_busy` is 0 in the following cycle unless a new miss is presented.
- Ignored inputs:
  - `miss_detected` while in FILL, with no re-latch.
  - `memory_data_valid` in IDLE, with no writes.
  - Valids beyond the 8th cannot occur, because the FSM is in IDLE by then.
- Reset:
  - `rst` has priority at every edge, including mid-fill.
  - Effect: state=IDLE, `issue_cnt`=`recv_cnt`=0, `block_address`=0.
  - From the cycle after the reset edge, while `rst` is held, all outputs are 0: `fsm_busy`, `mem_read_en`, `write_data_array`, `write_tag_array`, `memory_address`, `word_offset`, `fill_data`.
  - A partially filled block is never tagged.
- Output cleanliness: `memory_address` and `word_offset` are 0 whenever their strobes are 0, so they are always driven and never X.

Optional Feature:
- `CACHE_FILL_CWF_EN` (critical word first):
  - Defined:
    - Latch `start` = `miss_address`[3:1].
    - Request k goes to base + 2·((`start` + k) mod 8).
    - Data write k uses `word_offset` = (`start` + `recv_cnt`) mod 8.
    - The missed word is written first.
    - The tag is still written with the 8th word.
  - Undefined: `start` is forced to 0, giving the sequential order 0..7 described above.

Test Plan:
- Basic fill:
  - Stimulus: `miss_address`=0x1234 for one cycle; memory model with latency 4.
  - Requests 0x1230, 0x1232 … 0x123E on 8 consecutive cycles.
  - 8 data writes with offsets 0..7 and `fill_data` matching the model.
  - `write_tag_array` only on the final write, with `block_address`=0x1230.
  - `fsm_busy` high from the miss cycle through the final write, then 0.
- Gapped return:
  - Stimulus: model delivers the 8 valids with random 0–3 cycle gaps.
  - Exactly 8 data writes, offsets 0..7, a single tag pulse.
  - No `mem_read_en` after the 8th request.
- Ignored inputs:
  - Stimulus: `miss_detected` with `miss_address`=0x4000 mid-fill; also a spurious `memory_data_valid` in IDLE.
  - `block_address` stays 0x1230 during the fill.
  - No writes are produced in IDLE.
- Reset mid-fill:
  - Stimulus: `rst`=1 after the 3rd data write.
  - From the next cycle, while `rst` is held, all outputs are 0 and there is no tag write.
  - A new miss at 0xFFF6 then fills 0xFFF0..0xFFFE with no address wrap past 0xFFFE.
- Back-to-back misses:
  - Stimulus: `miss_detected` held high across completion, first at 0x0010, then at 0x0020.
  - The second fill starts at the edge after the tag write.
  - `fsm_busy` never drops between the two fills.
- `CACHE_FILL_CWF_EN` defined:
  - Stimulus: `miss_address`=0x123A.
  - Request order 0x123A, 0x123C, 0x123E, 0x1230 … 0x1238.
  - Offsets 5,6,7,0,1,2,3,4, with the tag written on offset 4.

Source files
------------

// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: miss-handling engine that refills one cache block from a
// pipelined, fixed-latency main memory. It latches the aligned block base and
// issues one word read per cycle. Each returned word is written into the data
// array as it arrives, and the tag is written together with the last word.
// Optional feature macro: CACHE_FILL_CWF_EN (critical word first). When it is
// defined, requests and data writes start at the missed word and wrap around
// the block. When it is undefined, the fill runs in sequential order from word 0.
module cache_fill_fsm #(
  parameter int WORDS_PER_BLOCK = 8,
  parameter int AWIDTH          = 16,
  parameter int DWIDTH          = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               miss_detected,
  input  logic [AWIDTH-1:0]                  miss_address,
  output logic                               fsm_busy,
  output logic                               mem_read_en,
  output logic [AWIDTH-1:0]                  memory_address,
  input  logic                               memory_data_valid,
  input  logic [DWIDTH-1:0]                  memory_data,
  output logic                               write_data_array,
  output logic [$clog2(WORDS_PER_BLOCK)-1:0] word_offset,
  output logic [DWIDTH-1:0]                  fill_data,
  output logic                               write_tag_array,
  output logic [AWIDTH-1:0]                  block_address
);
  localparam int OFFW = $clog2(WORDS_PER_BLOCK);
  // Words are 2 bytes wide, so the block occupies OFFW+1 byte-offset bits.
  localparam int BOFF = OFFW + 1;

  typedef enum logic {IDLE, FILL} state_t;

  state_t            state;
  // issue_cnt carries one extra bit; its MSB set means all requests are out.
  logic [OFFW:0]     issue_cnt;
  logic [OFFW-1:0]   recv_cnt;
  logic [OFFW-1:0]   start;
  logic [OFFW-1:0]   miss_start;
  logic [OFFW-1:0]   req_idx;

`ifdef CACHE_FILL_CWF_EN
  assign miss_start = miss_address[OFFW:1];
`else
  assign miss_start = '0;
`endif

  // Word indices wrap naturally within OFFW bits, so the base never carries.
  assign req_idx = start + issue_cnt[OFFW-1:0];

  // Fill sequencing: latch the miss, then count requests and returned words.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      issue_cnt     <= '0;
      recv_cnt      <= '0;
      start         <= '0;
      block_address <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (miss_detected) begin
            block_address <= {miss_address[AWIDTH-1:BOFF], {BOFF{1'b0}}};
            start         <= miss_start;
            issue_cnt     <= '0;
            recv_cnt      <= '0;
            state         <= FILL;
          end
        end
        FILL: begin
          if (!issue_cnt[OFFW]) issue_cnt <= issue_cnt + 1'b1;
          if (memory_data_valid) begin
            recv_cnt <= recv_cnt + 1'b1;
            if (recv_cnt == '1) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes and their qualified data. Payloads are forced to zero when idle.
  always_comb begin
    fsm_busy         = 1'b0;
    mem_read_en      = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    word_offset      = '0;
    fill_data        = '0;
    write_tag_array  = 1'b0;
    if (state == FILL) begin
      fsm_busy = 1'b1;
      if (!issue_cnt[OFFW]) begin
        mem_read_en    = 1'b1;
        memory_address = {block_address[AWIDTH-1:BOFF], req_idx, 1'b0};
      end
      if (memory_data_valid) begin
        write_data_array = 1'b1;
        word_offset      = start + recv_cnt;
        fill_data        = memory_data;
        write_tag_array  = (recv_cnt == '1);
      end
    end else begin
      // The stall must be raised in the same cycle the miss is seen.
      // It is held low while reset is asserted.
      fsm_busy = miss_detected && !rst;
    end
  end
endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb_cache_fill_fsm: randomized bench for cache_fill_fsm.
// A pipelined memory model answers the DUT's read requests. A queue-based
// reference predicts every output on every cycle.
module tb_cache_fill_fsm;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        miss_detected = 1'b0;
  logic [15:0] miss_address = '0;
  logic        memory_data_valid = 1'b0;
  logic [15:0] memory_data = '0;
  logic        fsm_busy, mem_read_en, write_data_array, write_tag_array;
  logic [15:0] memory_address, fill_data, block_address;
  logic [2:0]  word_offset;

  always #5 clk = ~clk;

  cache_fill_fsm dut (
    .clk(clk), .rst(rst), .miss_detected(miss_detected), .miss_address(miss_address),
    .fsm_busy(fsm_busy), .mem_read_en(mem_read_en), .memory_address(memory_address),
    .memory_data_valid(memory_data_valid), .memory_data(memory_data),
    .write_data_array(write_data_array), .word_offset(word_offset), .fill_data(fill_data),
    .write_tag_array(write_tag_array), .block_address(block_address)
  );

  int vecs = 0, errs = 0, cyc = 0;
  bit chk_en = 0, spurious = 0, gap_en = 0;
  int n_wr = 0, n_tag = 0, n_req = 0;
  logic [15:0] first_req = '0;

  // Memory environment: outstanding requests, each returned in order at its due cycle.
  logic [15:0] mq_addr[$];
  int          mq_due[$];
  int          last_due = 0;

  // Reference model: the addresses still to be requested and the offsets still to be written.
  bit          m_active = 0;
  logic [15:0] m_blk = '0;
  logic [15:0] m_req[$];
  logic [2:0]  m_off[$];

  function automatic logic [15:0] mdata(logic [15:0] a);
    return (a ^ 16'h5A5A) + {a[7:0], a[15:8]};
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    if (act !== exp) begin
      $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, exp);
      errs++;
    end
  endtask

  task automatic reset_stats();
    n_wr = 0; n_tag = 0; n_req = 0;
  endtask

  task automatic compare();
    logic        e_busy, e_rd, e_wr, e_tag;
    logic [15:0] e_addr, e_fill;
    logic [2:0]  e_off;
    e_busy = m_active || (miss_detected && !rst);
    e_rd   = m_active && (m_req.size() > 0);
    e_addr = e_rd ? m_req[0] : 16'h0;
    e_wr   = m_active && memory_data_valid;
    e_off  = '0; e_fill = '0; e_tag = 1'b0;
    if (e_wr) begin
      e_off  = m_off[0];
      e_fill = mdata(m_blk + 16'(m_off[0]) * 16'd2);
      e_tag  = (m_off.size() == 1);
    end
    vecs++;
    chk("fsm_busy", 32'(fsm_busy), 32'(e_busy));
    chk("mem_read_en", 32'(mem_read_en), 32'(e_rd));
    chk("memory_address", 32'(memory_address), 32'(e_addr));
    chk("write_data_array", 32'(write_data_array), 32'(e_wr));
    chk("word_offset", 32'(word_offset), 32'(e_off));
    chk("fill_data", 32'(fill_data), 32'(e_fill));
    chk("write_tag_array", 32'(write_tag_array), 32'(e_tag));
    chk("block_address", 32'(block_address), 32'(m_blk));
  endtask

  task automatic model_edge();
    logic [2:0] st;
    if (rst) begin
      m_active = 0; m_blk = '0; m_req.delete(); m_off.delete();
      mq_addr.delete(); mq_due.delete(); last_due = cyc;
    end else if (!m_active) begin
      if (miss_detected) begin
        m_active = 1;
        m_blk = miss_address & 16'hFFF0;
`ifdef CACHE_FILL_CWF_EN
        st = miss_address[3:1];
`else
        st = 3'd0;
`endif
        for (int k = 0; k < 8; k++) begin
          m_off.push_back(3'(st + 3'(k)));
          m_req.push_back(m_blk + 16'(3'(st + 3'(k))) * 16'd2);
        end
      end
    end else begin
      if (m_req.size() > 0) void'(m_req.pop_front());
      if (memory_data_valid) begin
        void'(m_off.pop_front());
        if (m_off.size() == 0) m_active = 0;
      end
    end
  endtask

  // One clock cycle. Drive the memory return, check the outputs, accept any
  // request, then advance the model at the edge.
  task automatic step();
    int d;
    @(negedge clk);
    if (spurious) begin
      memory_data_valid = 1'b1; memory_data = 16'hDEAD;
    end else if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
      memory_data_valid = 1'b1; memory_data = mdata(mq_addr[0]);
      void'(mq_addr.pop_front()); void'(mq_due.pop_front());
    end else begin
      memory_data_valid = 1'b0; memory_data = 16'($urandom);
    end
    #1;
    if (chk_en) compare();
    if (mem_read_en === 1'b1) begin
      d = cyc + 4;
      if (d < last_due + 1) d = last_due + 1;
      if (gap_en) d = (last_due + 1 + int'($urandom_range(0, 3)) > d) ? last_due + 1 + int'($urandom_range(0, 3)) : d;
      mq_addr.push_back(memory_address); mq_due.push_back(d); last_due = d;
      if (n_req == 0) first_req = memory_address;
      n_req++;
    end
    if (write_data_array === 1'b1) n_wr++;
    if (write_tag_array === 1'b1) n_tag++;
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
  endtask

  task automatic run_idle(int maxc);
    int k = 0;
    while (m_active && k < maxc) begin step(); k++; end
    if (m_active) begin
      $display("FAIL fill_timeout cyc=%0d actual=busy expected=idle", cyc);
      errs++;
    end
    step();
  endtask

  task automatic fill_counts(string nm);
    chk({nm, "_writes"}, n_wr, 8);
    chk({nm, "_tags"}, n_tag, 1);
    chk({nm, "_reqs"}, n_req, 8);
  endtask

  initial begin
    int k;
    // Reset: the first edge initialises the DUT; from then on every cycle is checked.
    rst = 1'b1; step(); chk_en = 1; step(); step();
    rst = 1'b0; step();

    // A spurious valid in IDLE must not produce any write.
    reset_stats();
    spurious = 1; step(); spurious = 0; step();
    chk("idle_no_write", n_wr, 0);

    // Basic fill at 0x1234. A second miss at 0x4000 mid-fill must be ignored.
    reset_stats(); gap_en = 0;
    miss_detected = 1; miss_address = 16'h1234; step(); miss_detected = 0;
    chk("model_blk_1230", m_blk, 16'h1230);
`ifndef CACHE_FILL_CWF_EN
    chk("model_req0_1230", m_req[0], 16'h1230);
    chk("model_req7_123E", m_req[7], 16'h123E);
`endif
    step(); step(); step();
    miss_detected = 1; miss_address = 16'h4000; step(); miss_detected = 0;
    run_idle(60);
    fill_counts("basic");
`ifndef CACHE_FILL_CWF_EN
    chk("basic_first_req", first_req, 16'h1230);
`endif

    // Random addresses, with memory returns spread out by random gaps.
    gap_en = 1;
    for (int i = 0; i < 8; i++) begin
      reset_stats();
      miss_detected = 1; miss_address = 16'($urandom); step(); miss_detected = 0;
      run_idle(100);
      fill_counts("gapped");
      k = int'($urandom_range(0, 2));
      for (int j = 0; j < k; j++) step();
    end

    // Reset after the third data write. No tag write may follow.
    reset_stats(); gap_en = 0;
    miss_detected = 1; miss_address = 16'h1234; step(); miss_detected = 0;
    k = 0;
    while (n_wr < 3 && k < 40) begin step(); k++; end
    chk("rst_reached_3_writes", n_wr, 3);
    rst = 1'b1; step(); step(); step();
    chk("rst_no_tag", n_tag, 0);
    rst = 1'b0; step();
    reset_stats();
    miss_detected = 1; miss_address = 16'hFFF6; step(); miss_detected = 0;
    chk("model_blk_FFF0", m_blk, 16'hFFF0);
`ifndef CACHE_FILL_CWF_EN
    chk("model_req7_FFFE", m_req[7], 16'hFFFE);
`endif
    run_idle(60);
    fill_counts("top_block");

    // Back-to-back misses: miss_detected is held high across the first completion.
    reset_stats();
    miss_detected = 1; miss_address = 16'h0010;
    k = 0;
    while (n_tag == 0 && k < 60) begin step(); k++; end
    chk("b2b_first_tag", n_tag, 1);
    miss_address = 16'h0020;
    k = 0;
    while (!(m_active && m_blk == 16'h0020) && k < 10) begin step(); k++; end
    chk("b2b_second_latch", m_blk, 16'h0020);
    miss_detected = 0;
    run_idle(60);
    chk("b2b_tags", n_tag, 2);

`ifdef CACHE_FILL_CWF_EN
    // Critical word first: the fill starts at word 5 and wraps around the block.
    reset_stats();
    miss_detected = 1; miss_address = 16'h123A; step(); miss_detected = 0;
    chk("cwf_model_req0", m_req[0], 16'h123A);
    chk("cwf_model_req3", m_req[3], 16'h1230);
    chk("cwf_model_off0", 32'(m_off[0]), 32'd5);
    chk("cwf_model_off7", 32'(m_off[7]), 32'd4);
    run_idle(60);
    fill_counts("cwf");
    chk("cwf_first_req", first_req, 16'h123A);
`endif

    step(); step();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
